mdu_seq: RTL and testbench

Sequential multiply/divide unit that executes the MULT/MULTU/DIV/DIVU operations requested by the multicycle controller and owns the HI/LO registers. It sits in the datapath beside the ALU.
- The controller initiates an operation by strobing `mul_c` or `div_c` with operands from Rs/Rt.
- It then waits for `done` before retiring the instruction.
- MTHI/MTLO writes and MFHI/MFLO reads use the same HI/LO registers.

---
 rtl/mdu_seq.sv | 171 +++++++++++++++++
 tb/tb_mdu_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, 34-cycle fixed latency.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mul_c,
    input  logic             div_c,
    input  logic             s_mdu,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_w,
    input  logic             lo_w,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    state_t             state_q;
    logic [5:0]         cnt_q;
    logic               is_div_q;
    logic               sgn_q;
    logic               sa_q;
    logic               sb_q;
    logic               bz_q;
    logic [WIDTH-1:0]   araw_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               busy_q;
    logic               done_q;
    logic               dz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] div_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        neg_a = s_mdu & a[WIDTH-1];
        neg_b = s_mdu & b[WIDTH-1];
        mag_a = neg_a ? (~a + 1'b1) : a;
        mag_b = neg_b ? (~b + 1'b1) : b;
    end

    // Multiply: acc = {partial product, remaining multiplier bits}; add into the top, shift right.
    always_comb begin
        msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_nxt = {msum, acc_q[WIDTH-1:1]};
    end

    // Divide: acc = {remainder, dividend/quotient}; shift left and trial-subtract the divisor.
    always_comb begin
        rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
        trial  = rem_sh - {1'b0, opnd_q};
        if (trial[WIDTH])
            div_nxt = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
            div_nxt = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        prod   = (sgn_q && (sa_q ^ sb_q)) ? (~acc_q + 1'b1) : acc_q;
        quot   = acc_q[WIDTH-1:0];
        rem    = acc_q[2*WIDTH-1:WIDTH];
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div_q) begin
            if (bz_q) begin
                fix_hi = araw_q;
                fix_lo = '1;
            end else begin
                fix_hi = (sgn_q && sa_q) ? (~rem + 1'b1) : rem;
                fix_lo = (sgn_q && (sa_q ^ sb_q)) ? (~quot + 1'b1) : quot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sgn_q    <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bz_q     <= 1'b0;
            araw_q   <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            if (hi_w) hi_q <= wdata;
            if (lo_w) lo_q <= wdata;
            case (state_q)
                S_IDLE: begin
                    if (mul_c || div_c) begin
                        // Multiply has priority; a simultaneous divide request is dropped.
                        state_q  <= mul_c ? S_MUL : S_DIV;
                        is_div_q <= ~mul_c;
                        cnt_q    <= '0;
                        sgn_q    <= s_mdu;
                        sa_q     <= neg_a;
                        sb_q     <= neg_b;
                        bz_q     <= (b == '0);
                        araw_q   <= a;
                        opnd_q   <= mul_c ? mag_a : mag_b;
                        acc_q    <= {{WIDTH{1'b0}}, (mul_c ? mag_b : mag_a)};
                        busy_q   <= 1'b1;
                    end
                end
                S_MUL: begin
                    acc_q <= mul_nxt;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == LAST_ITER) state_q <= S_FIX;
                end
                S_DIV: begin
                    acc_q <= div_nxt;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == LAST_ITER) state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    done_q  <= 1'b1;
                    dz_q    <= is_div_q & bz_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed plus randomized checks of mdu_seq against a plain-arithmetic HI/LO model.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mul_c = 1'b0;
    logic        div_c = 1'b0;
    logic        s_mdu = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_w = 1'b0;
    logic        lo_w = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    mdu_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .mul_c(mul_c), .div_c(div_c), .s_mdu(s_mdu),
        .a(a), .b(b), .hi_w(hi_w), .lo_w(lo_w), .wdata(wdata),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Result as {dz, hi, lo}, straight from the architectural definition of MULT/DIV.
    function automatic logic [64:0] model(input bit m, input bit s, input logic [31:0] x, input logic [31:0] y);
        longint xa, yb, p, q, r;
        xa = s ? longint'($signed(x)) : longint'({32'b0, x});
        yb = s ? longint'($signed(y)) : longint'({32'b0, y});
        if (m) begin
            p = xa * yb;
            return {1'b0, p[63:32], p[31:0]};
        end
        if (y == 32'd0) return {1'b1, x, 32'hFFFFFFFF};
        q = xa / yb;
        r = xa % yb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    // Drive a start in cycle 0; returns at the negedge of cycle 1 with requests low.
    task automatic launch(input bit m, input bit d, input bit s, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        mul_c = m; div_c = d; s_mdu = s; a = x; b = y;
        @(negedge clk);
        mul_c = 0; div_c = 0;
    endtask

    // Wait for done from cycle 'c0' and check latency, busy span, results, one-cycle pulses.
    task automatic finish(input string tag, input int c0, input logic [64:0] exp);
        int cyc = c0;
        int bcnt = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".latency"}, 32'(cyc), 32'd34);
        chk({tag, ".busycyc"}, 32'(bcnt), 32'(34 - c0));
        chk({tag, ".done"}, {31'b0, done}, 32'd1);
        chk({tag, ".busy0"}, {31'b0, busy}, 32'd0);
        chk({tag, ".hi"}, hi, exp[63:32]);
        chk({tag, ".lo"}, lo, exp[31:0]);
        chk({tag, ".dz"}, {31'b0, dz}, {31'b0, exp[64]});
        @(negedge clk);
        chk({tag, ".done_clr"}, {31'b0, done}, 32'd0);
        chk({tag, ".dz_clr"}, {31'b0, dz}, 32'd0);
    endtask

    task automatic run(input string tag, input bit m, input bit s, input logic [31:0] x, input logic [31:0] y);
        launch(m, !m, s, x, y);
        finish(tag, 1, model(m, s, x, y));
    endtask

    initial begin
        logic [64:0] e1, e2;
        int ndone;
        int c;
        bit m, s;
        logic [31:0] x, y;

        reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk("rst.done", {31'b0, done}, 32'd0);
        chk("rst.dz", {31'b0, dz}, 32'd0);
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);

        launch(1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        finish("multu_max", 1, {1'b0, 32'hFFFFFFFE, 32'h00000001});
        run("mult_neg3x5", 1, 1, 32'hFFFFFFFD, 32'd5);
        chk("mult_neg3x5.lit_hi", hi, 32'hFFFFFFFF);
        chk("mult_neg3x5.lit_lo", lo, 32'hFFFFFFF1);
        run("multu_fffd_x5", 1, 0, 32'hFFFFFFFD, 32'd5);
        chk("multu_fffd_x5.lit_hi", hi, 32'd4);
        run("divu_100_7", 0, 0, 32'd100, 32'd7);
        chk("divu_100_7.lit_lo", lo, 32'd14);
        chk("divu_100_7.lit_hi", hi, 32'd2);
        run("div_m7_2", 0, 1, 32'hFFFFFFF9, 32'd2);
        chk("div_m7_2.lit_lo", lo, 32'hFFFFFFFD);
        run("div_minint", 0, 1, 32'h80000000, 32'hFFFFFFFF);
        chk("div_minint.lit_lo", lo, 32'h80000000);
        chk("div_minint.lit_hi", hi, 32'h0);
        run("divz_s", 0, 1, 32'h12345678, 32'd0);
        run("divz_u", 0, 0, 32'h12345678, 32'd0);
        chk("divz_u.lit_hi", hi, 32'h12345678);

        // Both requests together: multiply only.
        launch(1, 1, 0, 32'd1000, 32'd3);
        finish("both_req", 1, model(1, 0, 32'd1000, 32'd3));

        // Divide request during a busy multiply is ignored.
        launch(1, 0, 1, 32'hFFFF0000, 32'h00012345);
        repeat (4) @(negedge clk);
        div_c = 1; a = 32'd9; b = 32'd2;
        @(negedge clk);
        div_c = 0;
        finish("div_ignored", 6, model(1, 1, 32'hFFFF0000, 32'h00012345));
        ndone = 0;
        repeat (45) begin
            if (done === 1'b1 || busy === 1'b1) ndone++;
            @(negedge clk);
        end
        chk("div_ignored.quiet", 32'(ndone), 32'd0);

        // Back-to-back start in the done cycle.
        e1 = model(0, 0, 32'hDEADBEEF, 32'd97);
        e2 = model(1, 1, 32'h7FFFFFFF, 32'h80000000);
        launch(0, 1, 0, 32'hDEADBEEF, 32'd97);
        c = 1;
        while (done !== 1'b1 && c < 40) begin @(negedge clk); c++; end
        chk("b2b.first_lat", 32'(c), 32'd34);
        chk("b2b.first_lo", lo, e1[31:0]);
        chk("b2b.first_hi", hi, e1[63:32]);
        mul_c = 1; s_mdu = 1; a = 32'h7FFFFFFF; b = 32'h80000000;
        @(negedge clk);
        mul_c = 0;
        finish("b2b.second", 1, e2);

        // Direct LO/HI writes while idle.
        @(negedge clk);
        lo_w = 1; wdata = 32'hA5A5A5A5;
        @(negedge clk);
        lo_w = 0;
        chk("mtlo", lo, 32'hA5A5A5A5);
        hi_w = 1; wdata = 32'h5A5A1234;
        @(negedge clk);
        hi_w = 0;
        chk("mthi", hi, 32'h5A5A1234);
        chk("mthi.lo_kept", lo, 32'hA5A5A5A5);

        // HI write landing on the FIX edge loses to the result.
        e1 = model(1, 0, 32'h00010001, 32'h00030003);
        launch(1, 0, 0, 32'h00010001, 32'h00030003);
        repeat (32) @(negedge clk);
        hi_w = 1; wdata = 32'hCAFEF00D;
        @(negedge clk);
        hi_w = 0;
        chk("fix_vs_mthi.done", {31'b0, done}, 32'd1);
        chk("fix_vs_mthi.hi", hi, e1[63:32]);
        chk("fix_vs_mthi.lo", lo, e1[31:0]);
        @(negedge clk);

        // Randomized operations against the model.
        for (int i = 0; i < 24; i++) begin
            m = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            x = $urandom();
            y = $urandom();
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 20));
                2: x = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            run($sformatf("rnd%0d_%s%s", i, m ? "mul" : "div", s ? "s" : "u"), m, s, x, y);
        end

        // Reset in cycle 10 of a divide aborts it.
        launch(0, 1, 1, 32'h0BADF00D, 32'd13);
        repeat (9) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("abort.busy", {31'b0, busy}, 32'd0);
        chk("abort.hi", hi, 32'd0);
        chk("abort.lo", lo, 32'd0);
        ndone = 0;
        repeat (45) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        chk("abort.no_done", 32'(ndone), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
